// File: rtl/sample_centering_pkg.sv
// Shared widths, state encoding and the saturation helper for the sample centering block.
// Everything here is common to the FSM top and the per-channel lanes.
package sample_centering_pkg;

    localparam int DATA_W    = 26;
    localparam int N_SAMPLES = 128;
    localparam int LOG2_N    = 7;
    localparam int ACC_W     = DATA_W + LOG2_N;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        MEAN   = 2'd2,
        REPLAY = 2'd3
    } state_t;

    // Clamp a DATA_W+1 bit signed difference into the DATA_W signed range.
    function automatic logic signed [DATA_W-1:0] sat_diff(input logic signed [DATA_W:0] d);
        if (d[DATA_W] != d[DATA_W-1]) begin
            sat_diff = d[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            sat_diff = d[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/sample_centering_lane.sv
// One channel of the centering datapath: frame buffer, running sum, mean register
// and the registered subtract/saturate stage. All control comes from the shared FSM.
module centering_lane
    import sample_centering_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_en,
    input  logic                     i_acc_load,
    input  logic [LOG2_N-1:0]        i_wr_addr,
    input  logic signed [DATA_W-1:0] i_data,
    input  logic                     i_mean_load,
    input  logic                     i_rd_en,
    input  logic [LOG2_N-1:0]        i_rd_addr,
    output logic signed [DATA_W-1:0] o_data,
    output logic signed [DATA_W-1:0] o_mean
);

    logic signed [DATA_W-1:0] r_buf [N_SAMPLES];
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [DATA_W-1:0] r_mean;
    logic signed [DATA_W-1:0] r_out;

    logic signed [ACC_W-1:0]  w_sample_ext;
    logic signed [DATA_W-1:0] w_rd_sample;
    logic signed [DATA_W:0]   w_diff;

    assign w_sample_ext = {{LOG2_N{i_data[DATA_W-1]}}, i_data};
    assign w_rd_sample  = r_buf[i_rd_addr];
    assign w_diff       = {w_rd_sample[DATA_W-1], w_rd_sample} - {r_mean[DATA_W-1], r_mean};

    // Buffer contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_buf[i_wr_addr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_acc_load) begin
            r_acc <= w_sample_ext;
        end else if (i_wr_en) begin
            r_acc <= r_acc + w_sample_ext;
        end
    end

    // Dropping the low LOG2_N bits of the signed sum is the flooring arithmetic shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mean <= '0;
        end else if (i_mean_load) begin
            r_mean <= r_acc[ACC_W-1:LOG2_N];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else if (i_rd_en) begin
            r_out <= sat_diff(w_diff);
        end
    end

    assign o_data = r_out;
    assign o_mean = r_mean;

endmodule

// File: rtl/sample_centering.sv
// Captures one N-sample frame on four channels, computes per-channel means, then
// replays the frame with the mean removed. FSM and counters are shared by all lanes.
module sample_centering
    import sample_centering_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data1,
    input  logic [DATA_W-1:0] i_in_data2,
    input  logic [DATA_W-1:0] i_in_data3,
    input  logic [DATA_W-1:0] i_in_data4,
    output logic              o_out_valid,
    output logic [DATA_W-1:0] o_out_data1,
    output logic [DATA_W-1:0] o_out_data2,
    output logic [DATA_W-1:0] o_out_data3,
    output logic [DATA_W-1:0] o_out_data4,
    output logic              o_out_last,
    output logic [DATA_W-1:0] o_mean1,
    output logic [DATA_W-1:0] o_mean2,
    output logic [DATA_W-1:0] o_mean3,
    output logic [DATA_W-1:0] o_mean4,
    output logic              o_busy,
    output logic              o_overrun,
    output state_t            o_state
);

    // Interface: i_in_valid qualifies one sample on all four channels for one cycle;
    // there is no ready. Samples are taken only in IDLE/ACCUM, anything else sets
    // the sticky overrun flag. o_out_valid marks one centered sample per cycle and
    // the downstream stage must take it; o_out_last tags the final one of the frame.

    state_t              r_state;
    state_t              w_next_state;
    logic [LOG2_N-1:0]   r_wr_cnt;
    logic [LOG2_N-1:0]   r_rd_cnt;
    logic                r_out_valid;
    logic                r_out_last;
    logic                r_overrun;

    logic                w_accept;
    logic                w_acc_load;
    logic                w_mean_load;
    logic                w_issue;
    logic                w_reject;
    logic                w_wr_last;
    logic                w_rd_last;
    logic [LOG2_N-1:0]   w_wr_addr;

    logic [DATA_W-1:0]   w_in_data  [4];
    logic [DATA_W-1:0]   w_out_data [4];
    logic [DATA_W-1:0]   w_mean     [4];

    assign w_in_data[0] = i_in_data1;
    assign w_in_data[1] = i_in_data2;
    assign w_in_data[2] = i_in_data3;
    assign w_in_data[3] = i_in_data4;

    assign w_wr_last = (r_wr_cnt == LOG2_N'(N_SAMPLES - 1));
    assign w_rd_last = (r_rd_cnt == LOG2_N'(N_SAMPLES - 1));

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_acc_load   = 1'b0;
        w_mean_load  = 1'b0;
        w_issue      = 1'b0;
        w_reject     = 1'b0;
        w_wr_addr    = r_wr_cnt;
        case (r_state)
            IDLE: begin
                if (i_in_valid) begin
                    w_accept     = 1'b1;
                    w_acc_load   = 1'b1;
                    w_wr_addr    = '0;
                    w_next_state = ACCUM;
                end
            end
            ACCUM: begin
                if (i_in_valid) begin
                    w_accept = 1'b1;
                    if (w_wr_last) begin
                        w_next_state = MEAN;
                    end
                end
            end
            MEAN: begin
                w_mean_load  = 1'b1;
                w_reject     = i_in_valid;
                w_next_state = REPLAY;
            end
            REPLAY: begin
                w_reject = i_in_valid;
                // The cycle that presents out_last is still REPLAY; IDLE follows it.
                if (r_out_last) begin
                    w_next_state = IDLE;
                end else begin
                    w_issue = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_out_valid <= w_issue;
            r_out_last  <= w_issue && w_rd_last;
            if (w_accept) begin
                r_wr_cnt <= w_wr_addr + LOG2_N'(1);
            end
            if (w_mean_load) begin
                r_rd_cnt <= '0;
            end else if (w_issue) begin
                r_rd_cnt <= r_rd_cnt + LOG2_N'(1);
            end
            if (w_reject) begin
                r_overrun <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        centering_lane u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_wr_en     (w_accept),
            .i_acc_load  (w_acc_load),
            .i_wr_addr   (w_wr_addr),
            .i_data      (w_in_data[g]),
            .i_mean_load (w_mean_load),
            .i_rd_en     (w_issue),
            .i_rd_addr   (r_rd_cnt),
            .o_data      (w_out_data[g]),
            .o_mean      (w_mean[g])
        );
    end

    assign o_out_valid = r_out_valid;
    assign o_out_last  = r_out_last;
    assign o_out_data1 = w_out_data[0];
    assign o_out_data2 = w_out_data[1];
    assign o_out_data3 = w_out_data[2];
    assign o_out_data4 = w_out_data[3];
    assign o_mean1     = w_mean[0];
    assign o_mean2     = w_mean[1];
    assign o_mean3     = w_mean[2];
    assign o_mean4     = w_mean[3];
    assign o_busy      = (r_state != IDLE);
    assign o_overrun   = r_overrun;
    assign o_state     = r_state;

endmodule

// File: tb/tb_sample_centering.sv
// Randomised and directed frames for sample_centering, checked against an arithmetic
// reference model through an expected-output queue drained by an independent monitor.
module tb_sample_centering;

    localparam int DW   = 26;
    localparam int N    = 128;
    localparam longint MAXV = 33554431;
    localparam longint MINV = -33554432;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic          in_valid;
    logic [DW-1:0] in_d   [4];
    logic          out_valid, out_last, busy, overrun;
    logic [DW-1:0] got_d  [4];
    logic [DW-1:0] got_m  [4];
    logic [1:0]    dbg_state;

    sample_centering dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (in_valid),
        .i_in_data1  (in_d[0]),
        .i_in_data2  (in_d[1]),
        .i_in_data3  (in_d[2]),
        .i_in_data4  (in_d[3]),
        .o_out_valid (out_valid),
        .o_out_data1 (got_d[0]),
        .o_out_data2 (got_d[1]),
        .o_out_data3 (got_d[2]),
        .o_out_data4 (got_d[3]),
        .o_out_last  (out_last),
        .o_mean1     (got_m[0]),
        .o_mean2     (got_m[1]),
        .o_mean3     (got_m[2]),
        .o_mean4     (got_m[3]),
        .o_busy      (busy),
        .o_overrun   (overrun),
        .o_state     (dbg_state)
    );

    int errors = 0;
    int checks = 0;
    logic [4*DW:0]        exp_q[$];
    logic signed [DW-1:0] smp [4][N];
    longint               exp_mean [4];
    int                   last_in_cyc;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got out_valid with empty queue at cycle %0d", cyc);
            end else begin
                logic [4*DW:0] e;
                e = exp_q.pop_front();
                for (int ch = 0; ch < 4; ch++) begin
                    check($sformatf("out_data%0d", ch + 1), longint'($signed(got_d[ch])),
                          longint'($signed(e[ch*DW +: DW])));
                end
                check("out_last", longint'(out_last), longint'(e[4*DW]));
            end
        end
    end

    // stimulus patterns
    task automatic fill(input int kind, input int cval);
        for (int i = 0; i < N; i++) begin
            for (int ch = 0; ch < 4; ch++) begin
                case (kind)
                    0: smp[ch][i] = DW'(cval);
                    1: smp[ch][i] = (ch == 0) ? DW'(i) : '0;
                    2: smp[ch][i] = (ch == 1) ? DW'(-1 - i) : '0;
                    3: smp[ch][i] = (ch == 2) ? ((i % 2 == 0) ? DW'(MAXV) : DW'(MINV)) : '0;
                    default: smp[ch][i] = DW'($urandom());
                endcase
            end
        end
    endtask

    // reference model: floor mean, then clamp each difference
    task automatic build_expect();
        for (int ch = 0; ch < 4; ch++) begin
            longint sum = 0;
            longint m;
            for (int i = 0; i < N; i++) sum += longint'(smp[ch][i]);
            m = sum / N;
            if ((sum % N != 0) && (sum < 0)) m = m - 1;
            exp_mean[ch] = m;
        end
        for (int i = 0; i < N; i++) begin
            logic [4*DW:0] e;
            e = '0;
            for (int ch = 0; ch < 4; ch++) begin
                longint d = longint'(smp[ch][i]) - exp_mean[ch];
                if (d > MAXV) d = MAXV;
                if (d < MINV) d = MINV;
                e[ch*DW +: DW] = DW'(d);
            end
            e[4*DW] = (i == N - 1);
            exp_q.push_back(e);
        end
    endtask

    // driver tasks
    task automatic send(input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                    in_valid = 1'b0;
                    for (int ch = 0; ch < 4; ch++) in_d[ch] = DW'($urandom());
                end
            end
            @(posedge clk); #1;
            in_valid = 1'b1;
            for (int ch = 0; ch < 4; ch++) in_d[ch] = smp[ch][i];
            if (i == N - 1) last_in_cyc = cyc;
        end
    endtask

    task automatic wait_frame(input bit pulses, input int abort_after);
        int cnt = 0;
        bit seen_last = 0;
        for (int k = 0; k < N + 20 && !seen_last; k++) begin
            @(posedge clk); #1;
            if (pulses && busy && (k == 0 || $urandom_range(0, 3) == 0)) begin
                in_valid = 1'b1;
                for (int ch = 0; ch < 4; ch++) in_d[ch] = DW'($urandom());
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid) begin
                cnt++;
                if (cnt == 1) begin
                    check("first_valid_cycle", cyc, last_in_cyc + 3);
                    for (int ch = 0; ch < 4; ch++)
                        check($sformatf("mean%0d", ch + 1), longint'($signed(got_m[ch])), exp_mean[ch]);
                end
                if (out_last) begin
                    check("last_cycle", cyc, last_in_cyc + N + 2);
                    check("out_count", cnt, N);
                    seen_last = 1;
                end
            end
            if (abort_after > 0 && cnt == abort_after) begin
                #2;
                in_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                check("abort_out_valid", longint'(out_valid), 0);
                check("abort_busy", longint'(busy), 0);
                check("abort_overrun", longint'(overrun), 0);
                check("abort_mean1", longint'(got_m[0]), 0);
                exp_q.delete();
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
        end
        if (!seen_last) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: out_last not seen, got %0d outputs expected %0d", cnt, N);
        end
    endtask

    task automatic run_frame(input int kind, input int cval, input bit gaps, input bit pulses,
                             input int abort_after);
        fill(kind, cval);
        build_expect();
        send(gaps);
        wait_frame(pulses, abort_after);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        for (int ch = 0; ch < 4; ch++) in_d[ch] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_last", longint'(out_last), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_overrun", longint'(overrun), 0);
        for (int ch = 0; ch < 4; ch++) begin
            check($sformatf("rst_out_data%0d", ch + 1), longint'(got_d[ch]), 0);
            check($sformatf("rst_mean%0d", ch + 1), longint'(got_m[ch]), 0);
        end
        rst_n = 1'b1;

        run_frame(0, 1000, 0, 0, 0);
        run_frame(1, 0, 0, 0, 0);
        run_frame(2, 0, 0, 0, 0);
        run_frame(3, 0, 0, 0, 0);
        check("overrun_clear", longint'(overrun), 0);
        run_frame(4, 0, 1, 1, 0);
        check("overrun_set", longint'(overrun), 1);
        run_frame(4, 0, 0, 0, 0);
        check("overrun_sticky", longint'(overrun), 1);
        run_frame(0, 7, 0, 0, 20);
        run_frame(0, 5, 0, 0, 0);

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("idle_at_end", longint'(busy), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sample_centering.md
Name: sample_centering

Overview:
- Sits directly downstream of the 4-channel sample ROM and upstream of whitening.
- Captures one frame of N samples per channel and computes each channel's mean.
- Replays the buffered frame with the mean subtracted, producing the zero-mean data FastICA requires.

Parameters:
- DATA_W, 26: signed sample width, for input and output.
- N_SAMPLES, 128: samples per frame per channel. Must be a power of two.
- LOG2_N, 7: log2(N_SAMPLES). Sets the counter width and the mean shift.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data1..4 hold a valid sample this cycle.
- in_data1..in_data4  in  DATA_W each  signed channel samples.
- out_valid  out  1  out_data1..4 hold a valid centered sample.
- out_data1..out_data4  out  DATA_W each  signed centered samples.
- out_last  out  1  marks the final centered sample of the frame.
- mean1..mean4  out  DATA_W each  signed channel means, valid from REPLAY onward.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky; in_valid arrived while not accepting.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State IDLE.
  - All counters and accumulators cleared.
  - out_valid, out_last, busy and overrun are 0.
  - out_data* and mean* are 0.
  - Buffer contents are don't-care.
- States: IDLE, ACCUM, MEAN, REPLAY.
- IDLE:
  - On in_valid, write the sample to buf[0] and load acc* with the sample.
  - Set wr_cnt=1 and go to ACCUM.
- ACCUM:
  - Each in_valid writes buf[wr_cnt], adds to acc*, and increments wr_cnt.
  - Cycles with in_valid=0 are gaps: no change.
  - A sample accepted with wr_cnt==N-1 is the last one; go to MEAN.
- Accumulators:
  - Width DATA_W+LOG2_N (33), signed.
  - Exact arithmetic; overflow is impossible.
- MEAN (exactly one cycle):
  - mean* <= acc* >>> LOG2_N, an arithmetic shift (floor).
  - The result is truncated to DATA_W; it always fits.
  - Then go to REPLAY with rd_cnt=0.
- REPLAY:
  - Reads buf[rd_cnt] every cycle with no gaps and no backpressure.
  - Output is registered: out_data* = sat(buf - mean*).
  - The difference is computed at DATA_W+1 bits, then saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - out_last accompanies the sample from rd_cnt==N-1.
  - Go to IDLE once the final sample has been issued.
- Timing: let the last input sample be accepted in cycle t.
  - MEAN occupies cycle t+1.
  - out_valid is high in cycles t+3 through t+N+2, contiguous.
  - out_last is high only in cycle t+N+2.
  - The block is back in IDLE and can accept a new sample in cycle t+N+3.
- in_valid in MEAN or REPLAY: sample ignored and overrun set to 1. overrun clears only on reset.
- Outputs between frames:
  - out_data* hold their last value when out_valid=0.
  - mean* hold until the next MEAN cycle.
- Reset mid-frame, in any state: return immediately to IDLE; the partial frame is discarded.
- Back-to-back frames: the next frame's first sample may arrive in the first IDLE cycle.

Decomposition:
- Package sample_centering_pkg holds:
  - DATA_W, N_SAMPLES, LOG2_N and ACC_W=DATA_W+LOG2_N.
  - The state enum {IDLE, ACCUM, MEAN, REPLAY}.
  - A saturate function from DATA_W+1 to DATA_W bits.
- One sub-module, centering_lane, instantiated 4 times. Each lane contains:
  - N x DATA_W buffer.
  - Accumulator.
  - Mean register.
  - Subtract/saturate output register.
- The top level holds the FSM, wr_cnt/rd_cnt, busy, overrun and out_valid/out_last, shared by all lanes.

Test Plan:
- Constant 1000 on all channels for 128 valid cycles:
  - mean*=1000.
  - 128 outputs of 0.
  - out_valid first seen 3 cycles after the last input.
  - out_last on the 128th output.
- Ramp 0..127 on ch1:
  - Sum is 8128, so mean1=63.
  - out_data1 runs from -63 to 64.
  - The other channels are held at 0 and produce all-zero outputs.
- Ramp -1..-128 on ch2:
  - Sum is -8256; floor gives mean2=-65.
  - out_data2 runs from 64 down to -63.
- Saturation: ch3 alternates 33554431 and -33554432:
  - mean3=-1.
  - Outputs alternate 33554431 (saturated) and -33554431.
- Random gaps in in_valid during ACCUM, plus in_valid pulses during REPLAY:
  - Results equal the gap-free frame.
  - overrun becomes 1 and stays set.
  - The frame still holds exactly 128 outputs.
- rst_n asserted mid-REPLAY, followed by a fresh constant-5 frame:
  - out_valid drops immediately.
  - The new frame gives mean*=5 and 128 outputs of 0.
